// File: rtl/l2_bus_pkg.sv
// Shared types and defaults for the L2-to-memory bus arbiter.
package l2_bus_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 64;

    localparam logic [2:0] SNP_NONE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_CHK,
        ST_WB,
        ST_MEM,
        ST_RELEASE
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; requesters that also assert pri win over plain ones.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic [1:0] pri,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    logic [1:0] hot;
    logic [1:0] cand;

    always_comb begin
        hot   = req & pri;
        // Only fall back to the plain requests when nobody asserts priority.
        cand  = (hot != 2'b00) ? hot : req;
        valid = |req;
        if (cand == 2'b11) begin
            grant = ~last;
        end else begin
            grant = cand[1];
        end
    end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Grants the main-memory port to L2 cache A or B, forwards snoops to the peer
// and lets a peer with a dirty hit write back before the owner's beat.
module l2_bus_arbiter
    import l2_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_low_a,
    input  logic              ce_low_b,
    input  logic              rw_low_a,
    input  logic              rw_low_b,
    input  logic [ADDR_W-1:0] addr_low_a,
    input  logic [ADDR_W-1:0] addr_low_b,
    input  logic [DATA_W-1:0] data_low_out_a,
    input  logic [DATA_W-1:0] data_low_out_b,
    output logic [DATA_W-1:0] data_low_in_a,
    output logic [DATA_W-1:0] data_low_in_b,
    output logic              RDY_low_a,
    output logic              RDY_low_b,
    input  logic [2:0]        snoop_req_a,
    input  logic [2:0]        snoop_req_b,
    input  logic [ADDR_W-1:0] addr_sp_out_a,
    input  logic [ADDR_W-1:0] addr_sp_out_b,
    output logic [2:0]        snoop_sig_a,
    output logic [2:0]        snoop_sig_b,
    output logic [ADDR_W-1:0] addr_sp_in_a,
    output logic [ADDR_W-1:0] addr_sp_in_b,
    input  logic              pro_a,
    input  logic              pro_b,
    output logic              ce_mem,
    output logic              rw_mem,
    output logic [ADDR_W-1:0] addr_mem,
    output logic [DATA_W-1:0] data_mem_out,
    input  logic [DATA_W-1:0] data_mem_in,
    input  logic              RDY_mem
);

    state_t            state_reg;
    owner_t            own_reg;
    owner_t            last_reg;
    logic              rw_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;

    logic grant;
    logic grant_valid;

    rr_arb2 u_arb (
        .req   ({ce_low_b, ce_low_a}),
        .pri   ({pro_b, pro_a}),
        .last  (last_reg),
        .grant (grant),
        .valid (grant_valid)
    );

    logic              win_rw;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [2:0]        win_snp;
    logic [ADDR_W-1:0] win_sp;

    assign win_rw   = grant ? rw_low_b       : rw_low_a;
    assign win_addr = grant ? addr_low_b     : addr_low_a;
    assign win_data = grant ? data_low_out_b : data_low_out_a;
    assign win_snp  = grant ? snoop_req_b    : snoop_req_a;
    assign win_sp   = grant ? addr_sp_out_b  : addr_sp_out_a;

    // The peer is whichever cache does not own the current transaction.
    logic              peer_is_b;
    logic              peer_pro;
    logic              peer_ce;
    logic              peer_rw;
    logic [ADDR_W-1:0] peer_addr;
    logic [DATA_W-1:0] peer_data;

    assign peer_is_b = (own_reg == OWN_A);
    assign peer_pro  = peer_is_b ? pro_b          : pro_a;
    assign peer_ce   = peer_is_b ? ce_low_b       : ce_low_a;
    assign peer_rw   = peer_is_b ? rw_low_b       : rw_low_a;
    assign peer_addr = peer_is_b ? addr_low_b     : addr_low_a;
    assign peer_data = peer_is_b ? data_low_out_b : data_low_out_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            own_reg       <= OWN_A;
            last_reg      <= OWN_B;
            rw_reg        <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            ce_mem        <= 1'b0;
            rw_mem        <= 1'b0;
            addr_mem      <= '0;
            data_mem_out  <= '0;
            data_low_in_a <= '0;
            data_low_in_b <= '0;
            RDY_low_a     <= 1'b0;
            RDY_low_b     <= 1'b0;
            snoop_sig_a   <= SNP_NONE;
            snoop_sig_b   <= SNP_NONE;
            addr_sp_in_a  <= '0;
            addr_sp_in_b  <= '0;
        end else begin
            RDY_low_a   <= 1'b0;
            RDY_low_b   <= 1'b0;
            snoop_sig_a <= SNP_NONE;
            snoop_sig_b <= SNP_NONE;

            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        own_reg  <= owner_t'(grant);
                        rw_reg   <= win_rw;
                        addr_reg <= win_addr;
                        data_reg <= win_data;
                        if (win_snp != SNP_NONE) begin
                            // The snoop output registers hold the latched code for the SNOOP cycle.
                            state_reg <= ST_SNOOP;
                            if (grant) begin
                                snoop_sig_a  <= win_snp;
                                addr_sp_in_a <= win_sp;
                            end else begin
                                snoop_sig_b  <= win_snp;
                                addr_sp_in_b <= win_sp;
                            end
                        end else begin
                            state_reg    <= ST_MEM;
                            ce_mem       <= 1'b1;
                            rw_mem       <= win_rw;
                            addr_mem     <= win_addr;
                            data_mem_out <= win_data;
                        end
                    end
                end

                ST_SNOOP: state_reg <= ST_CHK;

                ST_CHK: begin
                    if (peer_pro) begin
                        // A dirty peer must present its write before we preempt.
                        if (peer_ce && !peer_rw) begin
                            state_reg    <= ST_WB;
                            ce_mem       <= 1'b1;
                            rw_mem       <= 1'b0;
                            addr_mem     <= peer_addr;
                            data_mem_out <= peer_data;
                        end
                    end else begin
                        state_reg    <= ST_MEM;
                        ce_mem       <= 1'b1;
                        rw_mem       <= rw_reg;
                        addr_mem     <= addr_reg;
                        data_mem_out <= data_reg;
                    end
                end

                ST_WB: begin
                    if (RDY_mem) begin
                        ce_mem    <= 1'b0;
                        state_reg <= ST_MEM;
                        if (peer_is_b) begin
                            RDY_low_b <= 1'b1;
                        end else begin
                            RDY_low_a <= 1'b1;
                        end
                    end
                end

                ST_MEM: begin
                    // Coming from WB the bus is idle for one cycle before the owner's beat.
                    if (!ce_mem) begin
                        ce_mem       <= 1'b1;
                        rw_mem       <= rw_reg;
                        addr_mem     <= addr_reg;
                        data_mem_out <= data_reg;
                    end else if (RDY_mem) begin
                        ce_mem    <= 1'b0;
                        last_reg  <= own_reg;
                        state_reg <= ST_RELEASE;
                        if (own_reg == OWN_B) begin
                            RDY_low_b <= 1'b1;
                            if (rw_reg) begin
                                data_low_in_b <= data_mem_in;
                            end
                        end else begin
                            RDY_low_a <= 1'b1;
                            if (rw_reg) begin
                                data_low_in_a <= data_mem_in;
                            end
                        end
                    end
                end

                ST_RELEASE: state_reg <= ST_IDLE;

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Bench for l2_bus_arbiter: vector table plus hand-written arbitration, snoop-preemption and reset sequences.
module tb_l2_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        ce_low_a, ce_low_b, rw_low_a, rw_low_b;
    logic [23:0] addr_low_a, addr_low_b;
    logic [63:0] data_low_out_a, data_low_out_b;
    logic [63:0] data_low_in_a, data_low_in_b;
    logic        RDY_low_a, RDY_low_b;
    logic [2:0]  snoop_req_a, snoop_req_b;
    logic [23:0] addr_sp_out_a, addr_sp_out_b;
    logic [2:0]  snoop_sig_a, snoop_sig_b;
    logic [23:0] addr_sp_in_a, addr_sp_in_b;
    logic        pro_a, pro_b;
    logic        ce_mem, rw_mem;
    logic [23:0] addr_mem;
    logic [63:0] data_mem_out, data_mem_in;
    logic        RDY_mem;

    l2_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .ce_low_a(ce_low_a), .ce_low_b(ce_low_b),
        .rw_low_a(rw_low_a), .rw_low_b(rw_low_b),
        .addr_low_a(addr_low_a), .addr_low_b(addr_low_b),
        .data_low_out_a(data_low_out_a), .data_low_out_b(data_low_out_b),
        .data_low_in_a(data_low_in_a), .data_low_in_b(data_low_in_b),
        .RDY_low_a(RDY_low_a), .RDY_low_b(RDY_low_b),
        .snoop_req_a(snoop_req_a), .snoop_req_b(snoop_req_b),
        .addr_sp_out_a(addr_sp_out_a), .addr_sp_out_b(addr_sp_out_b),
        .snoop_sig_a(snoop_sig_a), .snoop_sig_b(snoop_sig_b),
        .addr_sp_in_a(addr_sp_in_a), .addr_sp_in_b(addr_sp_in_b),
        .pro_a(pro_a), .pro_b(pro_b),
        .ce_mem(ce_mem), .rw_mem(rw_mem), .addr_mem(addr_mem),
        .data_mem_out(data_mem_out), .data_mem_in(data_mem_in), .RDY_mem(RDY_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rw;
        logic [23:0] addr;
        logic [63:0] data;
    } mem_exp_t;

    typedef struct {
        logic [2:0]  code;
        logic [23:0] addr;
    } snp_exp_t;

    typedef struct {
        logic        cache;
        logic        rw;
        logic [23:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          lat;
        logic [2:0]  snp;
        logic [23:0] sp;
        int          exp_lat;
        logic [63:0] exp_data;
    } vec_t;

    mem_exp_t    mem_q[$];
    logic [63:0] rdy_q_a[$];
    logic [63:0] rdy_q_b[$];
    snp_exp_t    snp_q_a[$];
    snp_exp_t    snp_q_b[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          mem_lat  = 1;
    int          mem_wait = 0;
    logic [63:0] mem_rdata = '0;
    logic [63:0] last_a = '0;
    logic [63:0] last_b = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void push_mem(input logic rw, input logic [23:0] addr, input logic [63:0] data);
        mem_exp_t e;
        e.rw = rw; e.addr = addr; e.data = data;
        mem_q.push_back(e);
    endfunction

    // Expected data_low_in after the beat: new read data, or the held value for a write.
    function automatic void push_rdy(input logic c, input logic rw, input logic [63:0] rdata);
        if (!c) begin
            if (rw) last_a = rdata;
            rdy_q_a.push_back(last_a);
        end else begin
            if (rw) last_b = rdata;
            rdy_q_b.push_back(last_b);
        end
    endfunction

    function automatic void push_snp(input logic peer, input logic [2:0] code, input logic [23:0] addr);
        snp_exp_t e;
        e.code = code; e.addr = addr;
        if (peer) snp_q_b.push_back(e); else snp_q_a.push_back(e);
    endfunction

    // Memory model: answers each beat after mem_lat cycles and checks it against the scoreboard.
    initial begin
        RDY_mem = 1'b0;
        data_mem_in = '0;
        forever begin
            @(negedge clk);
            if (RDY_mem) begin
                RDY_mem = 1'b0;
                mem_wait = 0;
            end else if (ce_mem && reset) begin
                mem_wait++;
                if (mem_wait >= mem_lat) begin
                    RDY_mem = 1'b1;
                    data_mem_in = mem_rdata;
                    mem_wait = 0;
                    if (mem_q.size() == 0) begin
                        chk("mem_unexpected_beat", 64'(addr_mem), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        mem_exp_t e;
                        e = mem_q.pop_front();
                        chk("mem_rw_addr", 64'({rw_mem, addr_mem}), 64'({e.rw, e.addr}));
                        if (!e.rw) chk("mem_wdata", data_mem_out, e.data);
                    end
                end
            end else begin
                mem_wait = 0;
            end
        end
    end

    // Cache-side monitor: every RDY pulse and every forwarded snoop must be expected.
    initial begin
        forever begin
            @(negedge clk);
            if (RDY_low_a) begin
                if (rdy_q_a.size() == 0) chk("rdy_a_unexpected", 64'(RDY_low_a), 64'h0);
                else chk("data_low_in_a", data_low_in_a, rdy_q_a.pop_front());
            end
            if (RDY_low_b) begin
                if (rdy_q_b.size() == 0) chk("rdy_b_unexpected", 64'(RDY_low_b), 64'h0);
                else chk("data_low_in_b", data_low_in_b, rdy_q_b.pop_front());
            end
            if (snoop_sig_a != 3'b000) begin
                if (snp_q_a.size() == 0) chk("snoop_a_unexpected", 64'(snoop_sig_a), 64'h0);
                else begin
                    snp_exp_t e;
                    e = snp_q_a.pop_front();
                    chk("snoop_sig_a", 64'({snoop_sig_a, addr_sp_in_a}), 64'({e.code, e.addr}));
                end
            end
            if (snoop_sig_b != 3'b000) begin
                if (snp_q_b.size() == 0) chk("snoop_b_unexpected", 64'(snoop_sig_b), 64'h0);
                else begin
                    snp_exp_t e;
                    e = snp_q_b.pop_front();
                    chk("snoop_sig_b", 64'({snoop_sig_b, addr_sp_in_b}), 64'({e.code, e.addr}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic c, input logic ce, input logic rw, input logic [23:0] addr,
                         input logic [63:0] wd, input logic [2:0] snp, input logic [23:0] sp,
                         input logic pro);
        if (!c) begin
            ce_low_a = ce; rw_low_a = rw; addr_low_a = addr; data_low_out_a = wd;
            snoop_req_a = snp; addr_sp_out_a = sp; pro_a = pro;
        end else begin
            ce_low_b = ce; rw_low_b = rw; addr_low_b = addr; data_low_out_b = wd;
            snoop_req_b = snp; addr_sp_out_b = sp; pro_b = pro;
        end
    endtask

    task automatic wait_rdy(input logic c, input int max, output int cyc);
        logic r;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            r = c ? RDY_low_b : RDY_low_a;
            if (r) begin
                chk("ce_mem_low_with_rdy", 64'(ce_mem), 64'h0);
                break;
            end
            if (cyc >= max) begin
                n_checks++;
                $display("FAIL rdy_timeout cache=%0d: no RDY_low after %0d cycles, required one", c, cyc);
                break;
            end
        end
    endtask

    task automatic txn(input logic c, input logic rw, input logic [23:0] addr, input logic [63:0] wd,
                       input logic [2:0] snp, input logic [23:0] sp, input logic pro, output int cyc);
        drive(c, 1'b1, rw, addr, wd, snp, sp, pro);
        wait_rdy(c, 100, cyc);
        drive(c, 1'b0, 1'b0, '0, '0, 3'b000, '0, 1'b0);
        $display("txn cache=%s %s addr=%h snoop=%b cycles=%0d", c ? "B" : "A", rw ? "rd" : "wr", addr, snp, cyc);
        @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        int cyc, cyc_a, cyc_b, cyc_a2, cyc_b2;

        vecs[0] = '{1'b0, 1'b1, 24'hFE0004, 64'h0, 64'h3344556677889900, 2, 3'b000, 24'h0, 3, 64'h3344556677889900};
        vecs[1] = '{1'b1, 1'b0, 24'h000010, 64'h1122334455667788, 64'h0, 1, 3'b000, 24'h0, 2, 64'h0};
        vecs[2] = '{1'b1, 1'b1, 24'hFFFFFF, 64'h0, 64'hDEADBEEFCAFEF00D, 3, 3'b000, 24'h0, 4, 64'hDEADBEEFCAFEF00D};
        vecs[3] = '{1'b0, 1'b0, 24'h000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, 3'b000, 24'h0, 2, 64'h3344556677889900};
        vecs[4] = '{1'b0, 1'b1, 24'h343520, 64'h0, 64'h0123456789ABCDEF, 2, 3'b010, 24'h343520, 5, 64'h0123456789ABCDEF};
        vecs[5] = '{1'b1, 1'b1, 24'h0ABCDE, 64'h0, 64'h0F0F0F0F0F0F0F0F, 1, 3'b101, 24'h1ABCDE, 4, 64'h0F0F0F0F0F0F0F0F};
        vecs[6] = '{1'b0, 1'b0, 24'h3FFFFF, 64'h0, 64'h0, 3, 3'b111, 24'hFFFFFF, 6, 64'h0123456789ABCDEF};

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'b000, '0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b000, '0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_ce_mem", 64'(ce_mem), 64'h0);
        chk("rst_rdy", 64'({RDY_low_a, RDY_low_b}), 64'h0);
        chk("rst_snoop", 64'({snoop_sig_a, snoop_sig_b}), 64'h0);
        chk("rst_data_low_in_a", data_low_in_a, 64'h0);
        reset = 1'b1;
        @(negedge clk);

        // Simultaneous requests alternate A, B, A, B.
        mem_lat = 1;
        push_mem(1'b0, 24'h000100, 64'hA1A1A1A1A1A1A1A1);
        push_mem(1'b0, 24'h000200, 64'hB1B1B1B1B1B1B1B1);
        push_mem(1'b0, 24'h000101, 64'hA2A2A2A2A2A2A2A2);
        push_mem(1'b0, 24'h000201, 64'hB2B2B2B2B2B2B2B2);
        push_rdy(1'b0, 1'b0, '0); push_rdy(1'b0, 1'b0, '0);
        push_rdy(1'b1, 1'b0, '0); push_rdy(1'b1, 1'b0, '0);
        fork
            begin
                txn(1'b0, 1'b0, 24'h000100, 64'hA1A1A1A1A1A1A1A1, 3'b000, '0, 1'b0, cyc_a);
                txn(1'b0, 1'b0, 24'h000101, 64'hA2A2A2A2A2A2A2A2, 3'b000, '0, 1'b0, cyc_a2);
            end
            begin
                txn(1'b1, 1'b0, 24'h000200, 64'hB1B1B1B1B1B1B1B1, 3'b000, '0, 1'b0, cyc_b);
                txn(1'b1, 1'b0, 24'h000201, 64'hB2B2B2B2B2B2B2B2, 3'b000, '0, 1'b0, cyc_b2);
            end
        join
        chk("arb_lat_a1", 64'(cyc_a), 64'd2);
        chk("arb_lat_b1", 64'(cyc_b), 64'd5);
        chk("arb_lat_a2", 64'(cyc_a2), 64'd5);
        chk("arb_lat_b2", 64'(cyc_b2), 64'd5);

        for (int i = 0; i < 7; i++) begin
            mem_lat   = vecs[i].lat;
            mem_rdata = vecs[i].rdata;
            push_mem(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            if (!vecs[i].cache) rdy_q_a.push_back(vecs[i].exp_data);
            else rdy_q_b.push_back(vecs[i].exp_data);
            if (!vecs[i].cache) last_a = vecs[i].exp_data; else last_b = vecs[i].exp_data;
            if (vecs[i].snp != 3'b000) push_snp(~vecs[i].cache, vecs[i].snp, vecs[i].sp);
            txn(vecs[i].cache, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].snp, vecs[i].sp, 1'b0, cyc);
            chk($sformatf("vec%0d_latency", i), 64'(cyc), 64'(vecs[i].exp_lat));
        end

        // Snoop hits a dirty block in B: B's write-back goes to memory before A's read.
        mem_lat   = 2;
        mem_rdata = 64'h5555AAAA5555AAAA;
        push_snp(1'b1, 3'b010, 24'h343520);
        push_mem(1'b0, 24'h343520, 64'h2B2B2B2B2B2B2B2B);
        push_mem(1'b1, 24'h343520, '0);
        push_rdy(1'b1, 1'b0, '0);
        push_rdy(1'b0, 1'b1, 64'h5555AAAA5555AAAA);
        fork
            txn(1'b0, 1'b1, 24'h343520, '0, 3'b010, 24'h343520, 1'b0, cyc_a);
            begin
                @(negedge clk);
                drive(1'b1, 1'b1, 1'b0, 24'h343520, 64'h2B2B2B2B2B2B2B2B, 3'b000, '0, 1'b1);
                wait_rdy(1'b1, 100, cyc_b);
                drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b000, '0, 1'b0);
                $display("txn cache=B wr addr=343520 writeback cycles=%0d", cyc_b);
            end
        join
        chk("preempt_lat_b", 64'(cyc_b), 64'd4);
        chk("preempt_lat_a", 64'(cyc_a), 64'd8);

        // With last=B, B's priority request still beats A's plain one.
        mem_lat = 1;
        push_mem(1'b0, 24'h000777, 64'h7777777777777777);
        push_rdy(1'b1, 1'b0, '0);
        txn(1'b1, 1'b0, 24'h000777, 64'h7777777777777777, 3'b000, '0, 1'b0, cyc);
        mem_rdata = 64'hC0FFEE00C0FFEE00;
        push_mem(1'b0, 24'h000888, 64'h8888888888888888);
        push_mem(1'b1, 24'h000999, '0);
        push_rdy(1'b1, 1'b0, '0);
        push_rdy(1'b0, 1'b1, 64'hC0FFEE00C0FFEE00);
        fork
            txn(1'b0, 1'b1, 24'h000999, '0, 3'b000, '0, 1'b0, cyc_a);
            txn(1'b1, 1'b0, 24'h000888, 64'h8888888888888888, 3'b000, '0, 1'b1, cyc_b);
        join
        chk("pro_lat_b", 64'(cyc_b), 64'd2);
        chk("pro_lat_a", 64'(cyc_a), 64'd5);

        // Reset in the middle of a memory beat aborts it without any RDY pulse.
        mem_lat = 6;
        drive(1'b0, 1'b1, 1'b1, 24'h00ABCD, '0, 3'b000, '0, 1'b0);
        repeat (3) @(negedge clk);
        chk("mem_busy_before_reset", 64'(ce_mem), 64'h1);
        #2 reset = 1'b0;
        #1 chk("rst_async_ce_mem", 64'(ce_mem), 64'h0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'b000, '0, 1'b0);
        last_a = '0;
        last_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_data_cleared", data_low_in_a | data_low_in_b, 64'h0);
        reset = 1'b1;
        mem_lat   = 2;
        mem_rdata = 64'h0011223344556677;
        push_mem(1'b1, 24'h00ABCD, '0);
        push_rdy(1'b0, 1'b1, 64'h0011223344556677);
        txn(1'b0, 1'b1, 24'h00ABCD, '0, 3'b000, '0, 1'b0, cyc);
        chk("post_reset_lat", 64'(cyc), 64'd3);

        repeat (3) @(negedge clk);
        chk("mem_q_drain", 64'(mem_q.size()), 64'h0);
        chk("rdy_q_drain", 64'(rdy_q_a.size() + rdy_q_b.size()), 64'h0);
        chk("snp_q_drain", 64'(snp_q_a.size() + snp_q_b.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/l2_bus_arbiter.md
# l2_bus_arbiter

Shared lower-level bus controller that sits between two L2 cache instances (A and B) and the single main-memory port. It grants the memory bus to one cache at a time and forwards each granted cache's snoop request to the peer cache. When the peer answers a snoop with a dirty-writeback priority flag, it preempts the original transaction so the peer's write-back reaches memory first. Each cache-side beat is one read or write of a 64-bit block word, completed by a one-cycle ready pulse.

## Interface
Parameters:
- ADDR_W, 24, block address width on cache, snoop and memory sides
- DATA_W, 64, lower-level data width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- ce_low_a / ce_low_b  in  1  bus request from cache A / B (level, held until ready)
- rw_low_a / rw_low_b  in  1  1 = read, 0 = write
- addr_low_a / addr_low_b  in  ADDR_W  beat address
- data_low_out_a / data_low_out_b  in  DATA_W  write data from cache
- data_low_in_a / data_low_in_b  out  DATA_W  read data to cache (registered)
- RDY_low_a / RDY_low_b  out  1  one-cycle beat-complete pulse
- snoop_req_a / snoop_req_b  in  3  snoop code issued with the request; 3'b000 = none
- addr_sp_out_a / addr_sp_out_b  in  ADDR_W  snoop address
- snoop_sig_a / snoop_sig_b  out  3  snoop code forwarded from the peer
- addr_sp_in_a / addr_sp_in_b  out  ADDR_W  snoop address forwarded from the peer
- pro_a / pro_b  in  1  cache holds a dirty block hit by a snoop and needs priority write-back
- ce_mem  out  1  memory enable
- rw_mem  out  1  1 = read, 0 = write
- addr_mem  out  ADDR_W  memory address
- data_mem_out  out  DATA_W  memory write data
- data_mem_in  in  DATA_W  memory read data
- RDY_mem  in  1  memory beat done, sampled at clk edge

## Operation
- States: IDLE, SNOOP, CHK, WB, MEM, RELEASE.
- Owner register `own` (A/B) and `last` (last granted cache). Reset value of `last` is B, so A wins the first tie.
- IDLE arbitration among caches with ce_low high:
  - A requester with pro high beats one without.
  - Otherwise round-robin: the cache that is not `last` wins.
  - The winner's rw, address, data, snoop code and snoop address are latched.
- Exit from IDLE: a nonzero latched snoop code goes to SNOOP; a zero code goes to MEM.
- SNOOP (exactly 1 cycle):
  - Peer's snoop_sig = latched code; peer's addr_sp_in = latched snoop address.
  - Next state CHK.
  - snoop_sig is 0 in every other state.
- CHK (1 cycle): samples the peer's pro.
  - pro high and peer ce_low high with rw_low=0: go to WB.
  - pro high without a valid write request: stay in CHK until one appears.
  - Otherwise: go to MEM.
- WB: memory write of the peer's address and data.
  - On RDY_mem: RDY_low pulses to the peer.
  - Then return to MEM for the original owner. `last` is not updated.
- MEM: ce_mem=1, rw/addr/data from latched owner request.
  - On RDY_mem with a read: data_mem_in is registered into the owner's data_low_in.
  - Owner RDY_low=1 for the next cycle, ce_mem drops, `last` = owner, go to RELEASE.
- RELEASE (1 cycle): no grant; return to IDLE. This lets the cache drop or re-issue ce_low.
- A cache's ce_low dropping while it is owner is ignored; the transaction completes.

## Timing
- Reset values: all outputs 0, state IDLE. Asynchronous assertion aborts any beat with no RDY pulse; ce_mem falls immediately.
- All outputs are registered.
- Latency with no snoop:
  - Request sampled at edge t.
  - ce_mem high after edge t.
  - RDY_mem sampled at edge t+k.
  - RDY_low high for cycle t+k..t+k+1.
  - Next grant at the earliest at edge t+k+2.
- A snoop without preemption adds 2 cycles. A preemption adds the WB beat length plus 1 cycle.
- data_low_in holds its value until the next read beat to the same cache.
- Simultaneous pro_a and pro_b in IDLE: round-robin decides.
- RDY_mem in any state other than WB/MEM is ignored.

## Structure
- Package l2_bus_pkg: state enum, SNP_NONE=3'b000, default ADDR_W/DATA_W, owner encoding.
- Sub-module rr_arb2: 2-way round-robin with priority override, inputs req[1:0], pri[1:0], last; outputs grant and valid.

## Test plan
- A read 0xFE0004, no snoop, RDY_mem two cycles after ce_mem with data 0x3344556677889900 -> one-cycle RDY_low_a, data_low_in_a=0x3344556677889900, ce_mem low one cycle later.
- A and B request simultaneously after reset, then again -> A granted first, B second (alternation).
- A read miss with snoop_req_a=3'b010, addr_sp_out_a=0x343520, pro_b=0 -> snoop_sig_b=3'b010 and addr_sp_in_b=0x343520 for exactly one cycle, then A's memory read.
- Same as the previous scenario but pro_b=1 and B writes 0x2B2B2B2B2B2B2B2B to 0x343520 -> memory write by B completes first with RDY_low_b, then A's read with RDY_low_a.
- Reset low during MEM -> ce_mem=0 asynchronously, no RDY_low pulse; after release, a new request is granted normally.
- B requests with pro_b=1 while A requests plainly and last=B -> B is granted.
